// File: rtl/serial_adder_pkg.sv
// Purpose: shared types and constants for the bit-serial adder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   DEFAULT_WIDTH  default operand/sum width
//   state_t        FSM encoding; 2'd3 is unused and recovers to IDLE
//   maj3()         three-input majority, the carry function of a full adder
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Purpose: combinational 1-bit full adder cell, the only arithmetic in the serial adder.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//
// Ports:
//   a, b, cin  addend bits and incoming carry
//   s          sum bit  (a ^ b ^ cin)
//   co         carry out (majority of a, b, cin)
module fa_bit
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = maj3(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// Purpose: WIDTH-bit adder that processes one bit per clock, LSB first, through one fa_bit.
// Latency: start sampled at edge E0 -> done pulse in the cycle after edge E0+WIDTH.
// Backpressure: none; start is only honoured in IDLE, requests while busy/done are dropped.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any operation in flight
//   start      request, sampled only while idle
//   a, b, cin  operands, captured on the edge that accepts start
//   busy       high for exactly WIDTH cycles while bits are being shifted through
//   done       one-cycle pulse marking sum/cout as fresh
//   sum, cout  registered result; {cout,sum} = a + b + cin, held until the next result
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter value during the final bit's cycle.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;

    logic             bit_s;
    logic             bit_co;
    logic [WIDTH-1:0] sum_next;

    fa_bit u_fa_bit (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (bit_s),
        .co  (bit_co)
    );

    // New sum bits enter at the MSB, so after WIDTH shifts bit 0 of the
    // result has walked all the way down to bit 0 of the register.
    assign sum_next = {bit_s, sum_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next;
                    carry  <= bit_co;
                    cnt    <= cnt + 1'b1;
                    // Outputs are only touched here so sum never shows a
                    // partially shifted value.
                    if (cnt == LAST_BIT) begin
                        sum   <= sum_next;
                        cout  <= bit_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here; the extra
                    // IDLE cycle fixes the op period at WIDTH+2.
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    // Unused encoding: fall back to IDLE without touching results.
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Purpose: self-checking bench for serial_adder at WIDTH=8 and WIDTH=13.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_adder;

    localparam int W8  = 8;
    localparam int W13 = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           start8, cin8, busy8, done8, cout8;
    logic [W8-1:0]  a8, b8, sum8;
    logic           start13, cin13, busy13, done13, cout13;
    logic [W13-1:0] a13, b13, sum13;

    serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(W13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
        .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
    );

    int          n_tests;
    int          n_fail;
    logic [63:0] prev_sum  [2];
    logic [63:0] prev_cout [2];
    time         done_time [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [63:0] av,
                         input logic [63:0] bv, input logic cv);
        if (w == W8) begin
            start8 = st; a8 = av[W8-1:0]; b8 = bv[W8-1:0]; cin8 = cv;
        end else begin
            start13 = st; a13 = av[W13-1:0]; b13 = bv[W13-1:0]; cin13 = cv;
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == W8) ? busy8 : busy13;
    endfunction

    function automatic logic get_done(input int w);
        return (w == W8) ? done8 : done13;
    endfunction

    function automatic logic get_cout(input int w);
        return (w == W8) ? cout8 : cout13;
    endfunction

    function automatic logic [63:0] get_sum(input int w);
        return (w == W8) ? 64'(sum8) : 64'(sum13);
    endfunction

    // Called at a negedge with the DUT idle (or about to be). Issues one op,
    // follows it to completion and checks result, timing and output holding.
    task automatic run_op(input int w, input logic [63:0] av_in, input logic [63:0] bv_in,
                          input logic cv, input bit hold, input bit toggle);
        logic [63:0] mask, av, bv, total, exp_sum, exp_cout;
        int k, busy_cnt, cyc;
        mask     = (64'd1 << w) - 64'd1;
        av       = av_in & mask;
        bv       = bv_in & mask;
        total    = av + bv + 64'(cv);
        exp_sum  = total & mask;
        exp_cout = (total >> w) & 64'd1;
        k        = (w == W8) ? 0 : 1;

        drive(w, 1'b1, av, bv, cv);
        @(negedge clk);
        if (!hold) drive(w, 1'b0, av, bv, cv);
        busy_cnt = 0;
        cyc      = 0;
        while (!get_done(w) && cyc < w + 4) begin
            if (get_busy(w)) busy_cnt++;
            check("sum_held", get_sum(w), prev_sum[k]);
            check("cout_held", 64'(get_cout(w)), prev_cout[k]);
            if (toggle)
                drive(w, hold, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom_range(0, 1)));
            @(negedge clk);
            cyc++;
        end
        check("done_rise", 64'(get_done(w)), 64'd1);
        check("latency", 64'(cyc), 64'(w));
        check("busy_cycles", 64'(busy_cnt), 64'(w));
        check("busy_in_done", 64'(get_busy(w)), 64'd0);
        check("sum", get_sum(w), exp_sum);
        check("cout", 64'(get_cout(w)), exp_cout);
        done_time[k] = $time;
        prev_sum[k]  = exp_sum;
        prev_cout[k] = exp_cout;
        @(negedge clk);
        check("done_pulse", 64'(get_done(w)), 64'd0);
        check("idle_busy", 64'(get_busy(w)), 64'd0);
        check("sum_stable", get_sum(w), exp_sum);
    endtask

    task automatic period_test(input int w);
        time t1;
        int  k;
        k = (w == W8) ? 0 : 1;
        run_op(w, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        t1 = done_time[k];
        run_op(w, {32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        check("period", 64'(done_time[k] - t1), 64'((w + 2) * 10));
        drive(w, 1'b0, 64'd0, 64'd0, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 2; i++) begin
            prev_sum[i]  = 64'd0;
            prev_cout[i] = 64'd0;
            done_time[i] = 0;
        end
        rst = 1'b1;
        drive(W8, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(W13, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state of both instances.
        for (int w = W8; w <= W13; w += (W13 - W8)) begin
            check("rst_busy", 64'(get_busy(w)), 64'd0);
            check("rst_done", 64'(get_done(w)), 64'd0);
            check("rst_sum", get_sum(w), 64'd0);
            check("rst_cout", 64'(get_cout(w)), 64'd0);
        end
        rst = 1'b0;

        // Known vectors.
        run_op(W8, 64'h35, 64'h4A, 1'b0, 1'b0, 1'b0);
        run_op(W8, 64'hFF, 64'h01, 1'b1, 1'b0, 1'b0);
        run_op(W8, 64'hFF, 64'hFF, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of an op: discarded, outputs cleared.
        drive(W8, 1'b1, 64'h5A, 64'hC3, 1'b1);
        @(negedge clk);
        drive(W8, 1'b0, 64'h5A, 64'hC3, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy8), 64'd0);
        check("midrst_done", 64'(done8), 64'd0);
        check("midrst_sum", 64'(sum8), 64'd0);
        check("midrst_cout", 64'(cout8), 64'd0);
        for (int i = 0; i < 2; i++) begin
            prev_sum[i]  = 64'd0;
            prev_cout[i] = 64'd0;
        end
        repeat (W8 + 3) begin
            @(negedge clk);
            check("no_done_after_rst", 64'(done8), 64'd0);
            check("no_busy_after_rst", 64'(busy8), 64'd0);
        end
        run_op(W8, 64'h12, 64'h34, 1'b1, 1'b0, 1'b0);

        // Continuous start with operands changing mid-op.
        period_test(W8);
        period_test(W13);

        // Back-to-back ops with the first result held through idle cycles.
        run_op(W8, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("sum_idle", 64'(sum8), 64'd7);
        end
        run_op(W8, 64'd200, 64'd100, 1'b0, 1'b0, 1'b0);

        // Random ops, with all-ones operands mixed in for carry chains.
        for (int ws = 0; ws < 2; ws++) begin
            for (int n = 0; n < 1000; n++) begin
                int          w;
                logic [63:0] av, bv;
                w  = (ws == 0) ? W8 : W13;
                av = (n % 16 == 0) ? '1 : {32'd0, $urandom};
                bv = (n % 16 == 8) ? '1 : {32'd0, $urandom};
                repeat ($urandom_range(0, 2)) @(negedge clk);
                run_op(w, av, bv, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
